// File: rtl/tsmac_rx_pkt_fifo_if.sv
// Frame-beat stream into the RX packet FIFO and its valid/ready read port.
interface tsmac_rx_pkt_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_sop;
  logic                  in_last;
  logic                  in_err;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_last;

  modport master (
    output in_valid, in_data, in_sop, in_last, in_err, rd_ready,
    input  rd_valid, rd_data, rd_last
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_last, in_err, rd_ready,
    output rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/tsmac_rx_pkt_fifo.sv
// Frame-aware RX FIFO: only committed, error-free frames become readable;
// errored, truncated and overflowing frames are rewound out of storage.
//   state     | meaning
//   S_IDLE    | between frames, waiting for in_sop
//   S_WRITE   | storing beats of an uncommitted frame
//   S_DISCARD | dropping beats until in_last (no sop seen, or overflow)
module tsmac_rx_pkt_fifo #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH_WIDTH      = 9,
  parameter int ALMOST_FULL_NUM  = 500,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tsmac_rx_pkt_fifo_if.slave     bus,
  output logic [DEPTH_WIDTH:0]   rd_frames,
  output logic [DEPTH_WIDTH:0]   wr_water_level,
  output logic [DEPTH_WIDTH:0]   rd_water_level,
  output logic                   wr_full,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [15:0]            err_drop_cnt,
  output logic [15:0]            ovf_drop_cnt
);
  localparam int PW = DEPTH_WIDTH + 1;
  localparam logic [DEPTH_WIDTH:0] DEPTH_L = PW'(1 << DEPTH_WIDTH);
  localparam logic [DEPTH_WIDTH:0] AF_L    = PW'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_L    = PW'(ALMOST_EMPTY_NUM);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DISCARD} state_t;

  state_t                state;
  logic [DATA_WIDTH:0]   mem [1 << DEPTH_WIDTH];
  logic [DEPTH_WIDTH:0]  wr_ptr, commit_ptr, pop_ptr, rd_ptr, mem_addr, commit_level;
  logic [DATA_WIDTH:0]   mid_word;
  logic                  mid_valid;
  logic                  out_valid, out_last;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  mem_we, ovf, trunc, commit, bad_end, pop, out_load, fetch;

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign commit_level   = commit_ptr - pop_ptr;
  assign wr_water_level = wr_ptr - pop_ptr;
  assign rd_water_level = commit_level;
  assign wr_full        = (wr_water_level == DEPTH_L);
  assign almost_full    = (wr_water_level >= AF_L);
  assign almost_empty   = (rd_water_level <= AE_L);

  // A new sop always restarts at commit_ptr, so truncation and fresh frames share one path.
  always_comb begin
    mem_we   = 1'b0;
    ovf      = 1'b0;
    trunc    = 1'b0;
    mem_addr = wr_ptr;
    if (bus.in_valid) begin
      if (bus.in_sop) begin
        trunc = (state == S_WRITE);
        if (commit_level != DEPTH_L) begin
          mem_we   = 1'b1;
          mem_addr = commit_ptr;
        end else begin
          ovf = 1'b1;
        end
      end else if (state == S_WRITE) begin
        if (wr_water_level != DEPTH_L) mem_we = 1'b1;
        else                           ovf    = 1'b1;
      end
    end
  end

  assign commit  = mem_we & bus.in_last & ~bus.in_err;
  assign bad_end = mem_we & bus.in_last & bus.in_err;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr[DEPTH_WIDTH-1:0]] <= {bus.in_last, bus.in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      err_drop_cnt <= '0;
      ovf_drop_cnt <= '0;
    end else begin
      if (mem_we) begin
        if (!bus.in_last) begin
          wr_ptr <= mem_addr + 1'b1;
          state  <= S_WRITE;
        end else begin
          state <= S_IDLE;
          if (bus.in_err) begin
            wr_ptr <= commit_ptr;
          end else begin
            wr_ptr     <= mem_addr + 1'b1;
            commit_ptr <= mem_addr + 1'b1;
          end
        end
      end else if (ovf) begin
        wr_ptr <= commit_ptr;
        state  <= bus.in_last ? S_IDLE : S_DISCARD;
      end else if (bus.in_valid && state != S_WRITE) begin
        state <= bus.in_last ? S_IDLE : S_DISCARD;
      end
      err_drop_cnt <= sat_add(err_drop_cnt, {1'b0, trunc} + {1'b0, bad_end});
      ovf_drop_cnt <= sat_add(ovf_drop_cnt, {1'b0, ovf});
    end
  end

  // Two-stage prefetch (RAM read register, then output register) keeps one pop per cycle.
  assign pop      = out_valid & bus.rd_ready;
  assign out_load = mid_valid & (~out_valid | pop);
  assign fetch    = (rd_ptr != commit_ptr) & (~mid_valid | out_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_ptr   <= '0;
      rd_ptr    <= '0;
      mid_valid <= 1'b0;
      mid_word  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      rd_frames <= '0;
    end else begin
      if (pop) pop_ptr <= pop_ptr + 1'b1;
      if (fetch) begin
        mid_word  <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
        mid_valid <= 1'b1;
        rd_ptr    <= rd_ptr + 1'b1;
      end else if (out_load) begin
        mid_valid <= 1'b0;
      end
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= mid_word[DATA_WIDTH-1:0];
        out_last  <= mid_word[DATA_WIDTH];
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      if (commit && !(pop && out_last))      rd_frames <= rd_frames + 1'b1;
      else if (!commit && pop && out_last)   rd_frames <= rd_frames - 1'b1;
    end
  end

  assign bus.rd_valid = out_valid;
  assign bus.rd_data  = out_data;
  assign bus.rd_last  = out_last;
endmodule

// File: tb/tb_tsmac_rx_pkt_fifo.sv
// Directed scoreboard bench for tsmac_rx_pkt_fifo (32-deep, 8-bit, AF=28, AE=4).
`timescale 1ns/1ps
module tb_tsmac_rx_pkt_fifo;
  localparam int DW = 8;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tsmac_rx_pkt_fifo_if #(.DATA_WIDTH(DW)) bus ();

  logic [AW:0] rd_frames, wr_water_level, rd_water_level;
  logic        wr_full, almost_full, almost_empty;
  logic [15:0] err_drop_cnt, ovf_drop_cnt;

  tsmac_rx_pkt_fifo #(
    .DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .ALMOST_FULL_NUM(28), .ALMOST_EMPTY_NUM(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rd_frames(rd_frames), .wr_water_level(wr_water_level), .rd_water_level(rd_water_level),
    .wr_full(wr_full), .almost_full(almost_full), .almost_empty(almost_empty),
    .err_drop_cnt(err_drop_cnt), .ovf_drop_cnt(ovf_drop_cnt)
  );

  int errors = 0;
  int checks = 0;
  logic [DW:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every accepted beat against the queue, and checks hold stability.
  logic        prev_hold = 1'b0;
  logic [DW:0] prev_word = '0;
  logic [DW:0] exp_word;
  always @(negedge clk) begin
    if (rst_n && bus.rd_valid) begin
      if (prev_hold) check("rd_hold_stable", 32'({bus.rd_last, bus.rd_data}), 32'(prev_word));
      if (bus.rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got 0x%0h with no beat expected", {bus.rd_last, bus.rd_data});
        end else begin
          exp_word = exp_q.pop_front();
          check("rd_beat", 32'({bus.rd_last, bus.rd_data}), 32'(exp_word));
        end
      end
    end
    prev_hold = rst_n && bus.rd_valid && !bus.rd_ready;
    prev_word = {bus.rd_last, bus.rd_data};
  end

  task automatic beat(input logic [7:0] d, input logic sop, input logic last, input logic err);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sop   = sop;
    bus.in_last  = last;
    bus.in_err   = err;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_err   = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic err, input logic push);
    for (int i = 0; i < n; i++) begin
      if (push) exp_q.push_back({i == n - 1, 8'(base + i)});
      beat(8'(base + i), i == 0, i == n - 1, err && (i == n - 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.rd_valid) && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_rd_valid_low"}, bus.rd_valid, 0);
    check({name, "_rd_frames"}, rd_frames, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sop   = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_err   = 1'b0;
    bus.rd_ready = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // Reset state
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", {bus.rd_last, bus.rd_data}, 0);
    check("rst_levels", {rd_frames, wr_water_level, rd_water_level}, 0);
    check("rst_flags", {wr_full, almost_full, almost_empty}, 3'b001);
    check("rst_counters", {err_drop_cnt, ovf_drop_cnt}, 0);

    // Good 4-beat frame, commit latency and back-to-back readout
    bus.rd_ready = 1'b1;
    send_frame(4, 8'h11, 1'b0, 1'b1);
    check("t1_valid_n", bus.rd_valid, 0);
    check("t1_frames_1", rd_frames, 1);
    idle(1);
    check("t1_valid_n1", bus.rd_valid, 0);
    idle(1);
    check("t1_valid_n2", bus.rd_valid, 1);
    check("t1_data_0", bus.rd_data, 8'h11);
    for (int k = 1; k < 4; k++) begin
      idle(1);
      check("t1_b2b_valid", bus.rd_valid, 1);
      check("t1_b2b_data", bus.rd_data, 32'(8'h11 + k));
    end
    check("t1_last", bus.rd_last, 1);
    drain("t1");

    // Errored 6-beat frame, then a good 2-beat frame
    do_reset();
    bus.rd_ready = 1'b1;
    send_frame(6, 8'h20, 1'b1, 1'b0);
    check("t2_err_cnt", err_drop_cnt, 1);
    check("t2_wr_level_rewound", wr_water_level, 0);
    send_frame(2, 8'h30, 1'b0, 1'b1);
    check("t2_wr_level_2", wr_water_level, 2);
    check("t2_frames", rd_frames, 1);
    drain("t2");
    check("t2_err_final", err_drop_cnt, 1);

    // Overflow: 30-beat frame held, 5-beat frame overflows at beat 3
    do_reset();
    bus.rd_ready = 1'b0;
    send_frame(30, 8'h40, 1'b0, 1'b1);
    check("t3_rd_level_30", rd_water_level, 30);
    beat(8'h80, 1'b1, 1'b0, 1'b0);
    beat(8'h81, 1'b0, 1'b0, 1'b0);
    check("t3_full", wr_full, 1);
    check("t3_wr_level_32", wr_water_level, 32);
    beat(8'h82, 1'b0, 1'b0, 1'b0);
    check("t3_ovf_cnt", ovf_drop_cnt, 1);
    check("t3_wr_level_rewound", wr_water_level, 30);
    beat(8'h83, 1'b0, 1'b0, 1'b0);
    beat(8'h84, 1'b0, 1'b1, 1'b0);
    check("t3_rd_level_after", rd_water_level, 30);
    check("t3_ovf_final", ovf_drop_cnt, 1);
    check("t3_err_zero", err_drop_cnt, 0);
    bus.rd_ready = 1'b1;
    drain("t3");

    // Truncation by in_sop on beat 3
    do_reset();
    bus.rd_ready = 1'b1;
    beat(8'h50, 1'b1, 1'b0, 1'b0);
    beat(8'h51, 1'b0, 1'b0, 1'b0);
    send_frame(3, 8'h60, 1'b0, 1'b1);
    check("t4_err_cnt", err_drop_cnt, 1);
    drain("t4");

    // Reset mid-frame, headless beats afterwards, then a normal frame
    do_reset();
    bus.rd_ready = 1'b1;
    beat(8'h70, 1'b1, 1'b0, 1'b0);
    beat(8'h71, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(8'h72, 1'b0, 1'b0, 1'b0);
    beat(8'h73, 1'b0, 1'b1, 1'b0);
    idle(4);
    check("t5_no_output", bus.rd_valid, 0);
    check("t5_frames", rd_frames, 0);
    check("t5_almost_empty", almost_empty, 1);
    check("t5_wr_level", wr_water_level, 0);
    check("t5_counters", {err_drop_cnt, ovf_drop_cnt}, 0);
    send_frame(2, 8'h78, 1'b0, 1'b1);
    drain("t5");

    // Thresholds: almost_empty at 4/5 committed, almost_full at 27/28 written
    do_reset();
    bus.rd_ready = 1'b0;
    send_frame(4, 8'h01, 1'b0, 1'b1);
    check("t6_rd_level_4", rd_water_level, 4);
    check("t6_ae_at_4", almost_empty, 1);
    send_frame(1, 8'h05, 1'b0, 1'b1);
    check("t6_rd_level_5", rd_water_level, 5);
    check("t6_ae_at_5", almost_empty, 0);
    for (int i = 0; i < 23; i++) begin
      exp_q.push_back({i == 22, 8'(8'hA0 + i)});
      beat(8'(8'hA0 + i), i == 0, i == 22, 1'b0);
      if (i == 21) begin
        check("t6_wr_level_27", wr_water_level, 27);
        check("t6_af_at_27", almost_full, 0);
      end
      if (i == 22) begin
        check("t6_wr_level_28", wr_water_level, 28);
        check("t6_af_at_28", almost_full, 1);
      end
    end
    check("t6_frames_3", rd_frames, 3);
    bus.rd_ready = 1'b1;
    drain("t6");
    check("t6_af_after_drain", almost_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
